// File: rtl/fd_fetch_ctrl.sv
// rtl/fd_fetch_ctrl.sv - FAST-9 candidate scanner feeding the pixel register file
module fd_fetch_ctrl #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              dpAck,
  output logic [ADDR_W-1:0] sramAddr,
  output logic              sramRen,
  output logic [4:0]        regAddr,
  output logic              readen,
  output logic [7:0]        curX,
  output logic [7:0]        curY,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_EVAL, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE0  = ADDR_W'(3 * IMG_W + 3);
  localparam logic [7:0]        X_LAST = 8'(IMG_W - 4);
  localparam logic [7:0]        Y_LAST = 8'(IMG_H - 4);

  state_t            r_state, w_next;
  logic [4:0]        r_k;
  logic [ADDR_W-1:0] r_base;
  logic [7:0]        r_x, r_y;
  logic [4:0]        r_reg_addr;

  logic              w_last_k, w_row_end, w_last_cand;
  int                w_off;
  logic [ADDR_W-1:0] w_addr;

  assign w_last_k    = (r_k == 5'd16);
  assign w_row_end   = (r_x == X_LAST);
  assign w_last_cand = w_row_end && (r_y == Y_LAST);

  // Circle offsets are elaboration-time constants; only an adder remains.
  always_comb begin
    w_off = 0;
    case (r_k)
      5'd1:    w_off = -3 * IMG_W;
      5'd2:    w_off = -3 * IMG_W + 1;
      5'd3:    w_off = -2 * IMG_W + 2;
      5'd4:    w_off = -IMG_W + 3;
      5'd5:    w_off = 3;
      5'd6:    w_off = IMG_W + 3;
      5'd7:    w_off = 2 * IMG_W + 2;
      5'd8:    w_off = 3 * IMG_W + 1;
      5'd9:    w_off = 3 * IMG_W;
      5'd10:   w_off = 3 * IMG_W - 1;
      5'd11:   w_off = 2 * IMG_W - 2;
      5'd12:   w_off = IMG_W - 3;
      5'd13:   w_off = -3;
      5'd14:   w_off = -IMG_W - 3;
      5'd15:   w_off = -2 * IMG_W - 2;
      5'd16:   w_off = -3 * IMG_W - 1;
      default: w_off = 0;
    endcase
  end

  assign w_addr = r_base + ADDR_W'(w_off);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: if (w_last_k) w_next = S_DRAIN;
      S_DRAIN: w_next = S_EVAL;
      S_EVAL:  if (dpAck) w_next = w_last_cand ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_k        <= 5'd0;
      r_base     <= BASE0;
      r_x        <= 8'd3;
      r_y        <= 8'd3;
      r_reg_addr <= 5'd31;
    end else begin
      r_reg_addr <= (r_state == S_FETCH) ? r_k : 5'd31;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k    <= 5'd0;
            r_base <= BASE0;
            r_x    <= 8'd3;
            r_y    <= 8'd3;
          end
        end
        S_FETCH: r_k <= w_last_k ? 5'd0 : r_k + 5'd1;
        S_EVAL: begin
          // Row wrap skips the three right and three left border columns.
          if (dpAck && !w_last_cand) begin
            if (w_row_end) begin
              r_x    <= 8'd3;
              r_y    <= r_y + 8'd1;
              r_base <= r_base + ADDR_W'(7);
            end else begin
              r_x    <= r_x + 8'd1;
              r_base <= r_base + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sramRen  = (r_state == S_FETCH);
  assign sramAddr = sramRen ? w_addr : '0;
  assign regAddr  = r_reg_addr;
  assign readen   = (r_state == S_EVAL);
  assign curX     = r_x;
  assign curY     = r_y;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_fd_fetch_ctrl.sv
// tb/tb_fd_fetch_ctrl.sv - directed bench: 8x8 instance for sequencing, 64x64 for full scan
module tb_fd_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, dp_a, start_b;

  logic [5:0]  a_sramAddr;
  logic        a_sramRen, a_readen, a_busy, a_done;
  logic [4:0]  a_regAddr;
  logic [7:0]  a_curX, a_curY;

  logic [11:0] b_sramAddr;
  logic        b_sramRen, b_readen, b_busy, b_done;
  logic [4:0]  b_regAddr;
  logic [7:0]  b_curX, b_curY;

  int checks = 0;
  int failures = 0;
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  int b_readen_cnt = 0;
  int b_slot0 = -1;
  int b_lastx = -1;
  int b_lasty = -1;

  int t1_addr [17] = '{27, 3, 4, 13, 22, 30, 38, 45, 52, 51, 50, 41, 32, 24, 16, 9, 2};

  always #5 clk = ~clk;

  fd_fetch_ctrl #(.IMG_W(8), .IMG_H(8), .ADDR_W(6)) dut_a (
    .clock(clk), .reset(rst), .start(start_a), .dpAck(dp_a),
    .sramAddr(a_sramAddr), .sramRen(a_sramRen), .regAddr(a_regAddr),
    .readen(a_readen), .curX(a_curX), .curY(a_curY), .busy(a_busy), .done(a_done)
  );

  fd_fetch_ctrl #(.IMG_W(64), .IMG_H(64), .ADDR_W(12)) dut_b (
    .clock(clk), .reset(rst), .start(start_b), .dpAck(1'b1),
    .sramAddr(b_sramAddr), .sramRen(b_sramRen), .regAddr(b_regAddr),
    .readen(b_readen), .curX(b_curX), .curY(b_curY), .busy(b_busy), .done(b_done)
  );

  always @(negedge clk) begin
    if (a_done === 1'b1) a_done_cnt++;
    if (b_done === 1'b1) b_done_cnt++;
    if (b_readen === 1'b1) begin
      b_readen_cnt++;
      b_lastx = int'(b_curX);
      b_lasty = int'(b_curY);
    end
    if (b_sramRen === 1'b1 && b_regAddr === 5'd31) b_slot0 = int'(b_sramAddr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_addr"},   32'(a_sramAddr), 0);
    check({tag, "_ren"},    32'(a_sramRen),  0);
    check({tag, "_reg"},    32'(a_regAddr),  31);
    check({tag, "_readen"}, 32'(a_readen),   0);
    check({tag, "_x"},      32'(a_curX),     3);
    check({tag, "_y"},      32'(a_curY),     3);
    check({tag, "_busy"},   32'(a_busy),     0);
    check({tag, "_done"},   32'(a_done),     0);
  endtask

  // Entry: at the first FETCH sample of a candidate. Exit: one sample after dpAck.
  task automatic run_cand(input string tag, input int x, input int y, input int base);
    check({tag, "_readen_lo"}, 32'(a_readen),   0);
    check({tag, "_ren"},       32'(a_sramRen),  1);
    check({tag, "_slot0"},     32'(a_sramAddr), 32'(base));
    check({tag, "_x"},         32'(a_curX),     32'(x));
    check({tag, "_y"},         32'(a_curY),     32'(y));
    repeat (18) @(negedge clk);
    check({tag, "_eval_readen"}, 32'(a_readen), 1);
    check({tag, "_eval_x"},      32'(a_curX),   32'(x));
    check({tag, "_eval_y"},      32'(a_curY),   32'(y));
    dp_a = 1'b1;
    @(negedge clk);
    dp_a = 1'b0;
  endtask

  initial begin
    int bad;
    int n;
    rst = 1'b1; start_a = 1'b0; dp_a = 1'b0; start_b = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_a("rst");
    check("rst_b_busy", 32'(b_busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // T1 + T5: address/slot sequence with stray start and dpAck during FETCH
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      if (a_sramRen !== 1'b1) bad++;
      if (32'(a_sramAddr) !== 32'(t1_addr[i])) bad++;
      if (32'(a_regAddr) !== ((i == 0) ? 32'd31 : 32'(i - 1))) bad++;
      if (a_readen !== 1'b0 || a_busy !== 1'b1) bad++;
      if (a_curX !== 8'd3 || a_curY !== 8'd3) bad++;
      if (i == 1) check("t1_addr_k1", 32'(a_sramAddr), 3);
      if (i == 16) check("t1_addr_k16", 32'(a_sramAddr), 2);
      start_a = (i == 5);
      dp_a    = (i == 8);
      @(negedge clk);
    end
    start_a = 1'b0; dp_a = 1'b0;
    check("t1_fetch_seq_errors", 32'(bad), 0);
    check("t1_drain_ren", 32'(a_sramRen), 0);
    check("t1_drain_reg", 32'(a_regAddr), 16);
    check("t1_drain_readen", 32'(a_readen), 0);
    @(negedge clk);
    check("t1_eval_readen", 32'(a_readen), 1);
    check("t1_eval_reg", 32'(a_regAddr), 31);

    // T3 + T5: long EVAL wait with a stray start
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (a_readen !== 1'b1 || a_sramRen !== 1'b0 || a_regAddr !== 5'd31) bad++;
      @(negedge clk);
    end
    check("t3_hold_errors", 32'(bad), 0);
    dp_a = 1'b1;
    @(negedge clk);
    dp_a = 1'b0;

    // T2: remaining candidates, including row wrap
    run_cand("t2_c2", 4, 3, 28);
    run_cand("t2_c3", 3, 4, 35);
    run_cand("t2_c4", 4, 4, 36);
    check("t2_done_pulse", 32'(a_done), 1);
    check("t2_done_busy", 32'(a_busy), 1);
    @(negedge clk);
    check("t2_after_done", 32'(a_done), 0);
    check("t2_idle_busy", 32'(a_busy), 0);
    repeat (3) @(negedge clk);
    check("t2_done_count", 32'(a_done_cnt), 1);

    // T4: asynchronous reset at FETCH cycle 10
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    check("t4_pre_ren", 32'(a_sramRen), 1);
    #2 rst = 1'b1;
    #1 check_reset_a("t4_async");
    @(negedge clk);
    rst = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("t4_restart_addr", 32'(a_sramAddr), 27);
    check("t4_restart_x", 32'(a_curX), 3);
    check("t4_restart_y", 32'(a_curY), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // T6: full 64x64 scan with dpAck tied high
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (b_done_cnt == 0 && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check("t6_completed", 32'(n < 70000), 1);
    repeat (5) @(negedge clk);
    check("t6_readen_pulses", 32'(b_readen_cnt), 3364);
    check("t6_last_slot0", 32'(b_slot0), 3900);
    check("t6_last_x", 32'(b_lastx), 60);
    check("t6_last_y", 32'(b_lasty), 60);
    check("t6_done_count", 32'(b_done_cnt), 1);
    check("t6_idle_busy", 32'(b_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
